// File: rtl/d1s4439.sv
// Three-input pattern detector: combinational match on {a,b,c} plus a registered
// delayed match, a sticky seen flag and a saturating count of match entries.
module d1s4439 #(
  parameter logic [2:0] PATTERN = 3'b110,
  parameter logic [2:0] MASK    = 3'b111,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             clr,
  output logic             d,
  output logic             d_q,
  output logic             seen,
  output logic [CNT_W-1:0] hit_cnt
);

  logic entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Match path is purely combinational so it stays valid during reset.
  assign d     = (({a, b, c} & MASK) == (PATTERN & MASK));
  assign entry = d & ~d_q;

  // Registered monitor: one count per rising match, clr overrides counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= 1'b0;
      seen    <= 1'b0;
      hit_cnt <= '0;
    end else begin
      d_q <= d;
      if (clr) begin
        hit_cnt <= '0;
        seen    <= 1'b0;
      end else if (entry) begin
        hit_cnt <= sat_inc(hit_cnt);
        seen    <= 1'b1;
      end else if (d) begin
        seen    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_d1s4439.sv
// Directed bench for d1s4439: default, 2-bit-counter and masked instances share stimulus.
module tb_d1s4439;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic clr = 1'b0;

  logic       d0, dq0, seen0;
  logic [7:0] cnt0;
  logic       d1, dq1, seen1;
  logic [1:0] cnt1;
  logic       d2, dq2, seen2;
  logic [7:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d1s4439 u0 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
              .d(d0), .d_q(dq0), .seen(seen0), .hit_cnt(cnt0));

  d1s4439 #(.CNT_W(2)) u1 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .clr(clr),
              .d(d1), .d_q(dq1), .seen(seen1), .hit_cnt(cnt1));

  d1s4439 #(.PATTERN(3'b110), .MASK(3'b110)) u2 (.clk(clk), .rst(rst), .a(a), .b(b), .c(c),
              .clr(clr), .d(d2), .d_q(dq2), .seen(seen2), .hit_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    // Sweep all codes while reset is held: d must still be valid, registers cleared.
    for (int i = 0; i < 8; i++) begin
      set_in(3'(i));
      #2;
      chk("sweep_d", 32'(d0), (i == 6) ? 32'd1 : 32'd0);
      chk("sweep_d_mask", 32'(d2), (i >= 6) ? 32'd1 : 32'd0);
      #3;
    end
    chk("rst_dq", 32'(dq0), 32'd0);
    chk("rst_seen", 32'(seen0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);

    step();
    set_in(3'b000);
    rst = 1'b0;
    step();
    chk("idle_dq", 32'(dq0), 32'd0);
    chk("idle_cnt", 32'(cnt0), 32'd0);
    chk("idle_seen", 32'(seen0), 32'd0);

    // Hold 110 for five cycles: counted once, d_q lags d by one cycle.
    set_in(3'b110);
    #1;
    chk("lag_d", 32'(d0), 32'd1);
    chk("lag_dq_before", 32'(dq0), 32'd0);
    step();
    chk("hold_dq", 32'(dq0), 32'd1);
    chk("hold_cnt1", 32'(cnt0), 32'd1);
    chk("hold_seen", 32'(seen0), 32'd1);
    chk("sat_seq1", 32'(cnt1), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_cnt", 32'(cnt0), 32'd1);
      chk("hold_dq_k", 32'(dq0), 32'd1);
    end

    // Leave via 111 then re-enter.
    set_in(3'b111);
    #1;
    chk("leave_d", 32'(d0), 32'd0);
    step();
    chk("leave_dq", 32'(dq0), 32'd0);
    chk("leave_cnt", 32'(cnt0), 32'd1);
    set_in(3'b110);
    step();
    chk("reentry_cnt", 32'(cnt0), 32'd2);
    chk("reentry_dq", 32'(dq0), 32'd1);
    chk("sat_seq2", 32'(cnt1), 32'd2);

    // Three more entries: 2-bit counter saturates at 3.
    for (int k = 0; k < 3; k++) begin
      set_in(3'b000);
      step();
      set_in(3'b110);
      step();
      chk("entry_cnt8", 32'(cnt0), 32'(3 + k));
      chk("sat_seq", 32'(cnt1), 32'd3);
    end

    // Asynchronous reset mid-cycle with a live match on the inputs.
    #1;
    rst = 1'b1;
    #1;
    chk("arst_dq", 32'(dq0), 32'd0);
    chk("arst_seen", 32'(seen0), 32'd0);
    chk("arst_cnt", 32'(cnt0), 32'd0);
    chk("arst_cnt_sat", 32'(cnt1), 32'd0);
    chk("arst_d", 32'(d0), 32'd1);
    step();
    chk("arst_hold_cnt", 32'(cnt0), 32'd0);
    chk("arst_hold_dq", 32'(dq0), 32'd0);
    rst = 1'b0;
    step();
    chk("rel_dq", 32'(dq0), 32'd1);
    chk("rel_cnt", 32'(cnt0), 32'd1);
    chk("rel_seen", 32'(seen0), 32'd1);

    // clr on the same edge as an entry: clr wins, d_q still follows d.
    set_in(3'b000);
    step();
    chk("pre_clr_cnt", 32'(cnt0), 32'd1);
    set_in(3'b110);
    clr = 1'b1;
    step();
    chk("clr_cnt", 32'(cnt0), 32'd0);
    chk("clr_seen", 32'(seen0), 32'd0);
    chk("clr_dq", 32'(dq0), 32'd1);
    clr = 1'b0;
    step();
    chk("post_clr_cnt", 32'(cnt0), 32'd0);
    chk("post_clr_seen", 32'(seen0), 32'd1);
    set_in(3'b000);
    step();
    set_in(3'b110);
    step();
    chk("recount_cnt", 32'(cnt0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
